binary_to_bcd_converter: RTL and testbench



---
 rtl/binary_to_bcd_converter_pkg.sv | 23 ++
 rtl/binary_to_bcd_converter_bcd_digit_adjust.sv | 17 +
 rtl/binary_to_bcd_converter.sv | 138 +++++++++++++
 tb/tb_binary_to_bcd_converter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
// Also holds a helper giving the largest value representable in N BCD digits.
package binary_to_bcd_converter_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic [63:0] max_bcd_value(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/binary_to_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module bcd_digit_adjust
   import binary_to_bcd_converter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one shift per clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module binary_to_bcd_converter
   import binary_to_bcd_converter_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [WIDTH-1:0]          bin,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] bcd,
   output logic                      overflow
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [63:0] MAX_VAL = max_bcd_value(DIGITS);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [BCD_W-1:0]   sc_q, sc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               overflow_q, overflow_d;
   logic [BCD_W-1:0]   adj;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_i (sc_q[g*DIGIT_W +: DIGIT_W]),
         .digit_o (adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // Final display value: all BLANK on overflow, optionally blank leading zeros.
   function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] sc,
                                                      input logic ovf);
      logic [BCD_W-1:0] r;
      r = sc;
      if (ovf) begin
         r = {DIGITS{BLANK_DIGIT}};
      end
`ifdef LEADING_ZERO_BLANK_EN
      else begin
         logic seen;
         seen = 1'b0;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!seen && (r[i*DIGIT_W +: DIGIT_W] == '0)) begin
               r[i*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
            end else begin
               seen = 1'b1;
            end
         end
      end
`endif
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      sc_d       = sc_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SHIFT;
               sh_d       = bin;
               sc_d       = '0;
               cnt_d      = CNT_W'(WIDTH);
               ovf_pend_d = (64'(bin) > MAX_VAL);
               busy_d     = 1'b1;
            end
         end
         ST_SHIFT: begin
            // Top bit of the top digit falls off; only reachable when overflow is pending.
            sc_d  = {adj[BCD_W-2:0], sh_q[WIDTH-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bcd_d      = format_result(sc_q, ovf_pend_q);
            overflow_d = ovf_pend_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sh_q       <= '0;
         sc_q       <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         sc_q       <= sc_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter (WIDTH=14, DIGITS=4) against a
// decimal reference model; honours LEADING_ZERO_BLANK_EN when defined.
module tb_binary_to_bcd_converter;

   localparam int WIDTH  = 14;
   localparam int DIGITS = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  bin = '0;
   logic              busy;
   logic              done;
   logic [15:0]       bcd;
   logic              overflow;

   int total = 0;
   int bad   = 0;

   binary_to_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Decimal reference: digit i is (v / 10^i) mod 10; a leading zero is any digit i>0 with v < 10^i.
   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int n;
      if (v > 9999) return 16'hFFFF;
      n = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(n % 10);
         n = n / 10;
      end
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 1; i < DIGITS; i++) begin
         if (v < 10 ** i) r[i*4 +: 4] = 4'hF;
      end
`endif
      return r;
   endfunction

   function automatic logic ref_ovf(input int v);
      return (v > 9999);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done; n counts clock edges consumed.
   task automatic wait_done(input int limit, output int n, output bit timeout);
      n = 0;
      timeout = 1'b0;
      while (!done && n < limit) begin
         step();
         n++;
      end
      if (!done) timeout = 1'b1;
   endtask

   // Issues one conversion from IDLE; returns latency and busy-high cycles before done.
   task automatic convert(input int v, output int lat, output int busy_cnt, output bit timeout);
      start = 1'b1;
      bin   = WIDTH'(v);
      step();
      start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      timeout = 1'b0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         step();
         lat++;
      end
      if (!done) timeout = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_zero();
      int lat, bc;
      bit to;
      convert(0, lat, bc, to);
      total++; if (to) begin bad++; $display("FAIL zero_timeout: no done within 40 cycles"); end
      total++; if (lat != 15) begin bad++; $display("FAIL zero_latency: got %0d want 15", lat); end
      total++; if (bcd !== ref_bcd(0)) begin bad++; $display("FAIL zero_bcd: got %h want %h", bcd, ref_bcd(0)); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL zero_ovf: got %b want 0", overflow); end
      step();
   endtask

   task automatic test_9999();
      int lat, bc;
      bit to;
      convert(9999, lat, bc, to);
      total++; if (to || lat != 15) begin bad++; $display("FAIL max_latency: got %0d want 15", lat); end
      total++; if (bc != 15) begin bad++; $display("FAIL max_busy_cycles: got %0d want 15", bc); end
      total++; if (bcd !== ref_bcd(9999)) begin bad++; $display("FAIL max_bcd: got %h want %h", bcd, ref_bcd(9999)); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL max_ovf: got %b want 0", overflow); end
      step();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_width: got %b want 0", done); end
   endtask

   task automatic test_overflow();
      int vals[3] = '{10000, 16383, 1234};
      int lat, bc;
      bit to;
      foreach (vals[i]) begin
         convert(vals[i], lat, bc, to);
         total++;
         if (to || bcd !== ref_bcd(vals[i])) begin
            bad++; $display("FAIL ovf_bcd_%0d: got %h want %h", vals[i], bcd, ref_bcd(vals[i]));
         end
         total++;
         if (overflow !== ref_ovf(vals[i])) begin
            bad++; $display("FAIL ovf_flag_%0d: got %b want %b", vals[i], overflow, ref_ovf(vals[i]));
         end
         step();
      end
   endtask

   task automatic test_blank();
      int lat, bc;
      bit to;
      logic [15:0] want42, want0;
`ifdef LEADING_ZERO_BLANK_EN
      want42 = 16'hFF42;
      want0  = 16'hFFF0;
`else
      want42 = 16'h0042;
      want0  = 16'h0000;
`endif
      convert(42, lat, bc, to);
      total++; if (to || bcd !== want42) begin bad++; $display("FAIL blank_42: got %h want %h", bcd, want42); end
      step();
      convert(0, lat, bc, to);
      total++; if (to || bcd !== want0) begin bad++; $display("FAIL blank_0: got %h want %h", bcd, want0); end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      bit to;
      start = 1'b1;
      bin   = WIDTH'(5678);
      step();
      repeat (3) step();
      bin = WIDTH'(1111);
      wait_done(30, n, to);
      total++; if (to || bcd !== ref_bcd(5678)) begin bad++; $display("FAIL b2b_first: got %h want %h", bcd, ref_bcd(5678)); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_on_done: busy got %b want 0", busy); end
      step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
      start = 1'b0;
      wait_done(30, n, to);
      total++; if (to || n != 15) begin bad++; $display("FAIL b2b_latency: got %0d want 15", n); end
      total++; if (bcd !== ref_bcd(1111)) begin bad++; $display("FAIL b2b_second: got %h want %h", bcd, ref_bcd(1111)); end
      step();
   endtask

   task automatic test_reset_mid();
      int lat, bc, events;
      bit to;
      convert(321, lat, bc, to);
      total++; if (to || bcd !== ref_bcd(321)) begin bad++; $display("FAIL rst_pre: got %h want %h", bcd, ref_bcd(321)); end
      step();
      start = 1'b1;
      bin   = WIDTH'(8765);
      step();
      start = 1'b0;
      repeat (6) step();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_ovf: got %b want 0", overflow); end
      total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL rst_mid_bcd: got %h want 0000", bcd); end
      @(negedge clk);
      rst_n = 1'b1;
      events = 0;
      repeat (25) begin
         step();
         if (done || busy) events++;
      end
      total++; if (events != 0) begin bad++; $display("FAIL rst_no_done: got %0d active cycles want 0", events); end
   endtask

   task automatic test_random();
      int v, n, hold_err;
      bit to;
      logic [15:0] snap;
      for (int it = 0; it < 25; it++) begin
         case (it % 5)
            0: v = 9999 + int'($urandom_range(0, 2));
            default: v = int'($urandom_range(0, 16383));
         endcase
         start = 1'b1;
         bin   = WIDTH'(v);
         step();
         start = 1'b0;
         repeat (3) step();
         start = 1'b1;
         bin   = WIDTH'($urandom_range(0, 16383));
         step();
         start = 1'b0;
         bin   = WIDTH'($urandom_range(0, 16383));
         wait_done(30, n, to);
         total++;
         if (to || n != 11) begin bad++; $display("FAIL rand_latency_%0d: got %0d want 11", v, n); end
         total++;
         if (bcd !== ref_bcd(v) || overflow !== ref_ovf(v)) begin
            bad++; $display("FAIL rand_%0d: got %h/%b want %h/%b", v, bcd, overflow, ref_bcd(v), ref_ovf(v));
         end
         snap = bcd;
         hold_err = 0;
         repeat (3) begin
            step();
            if (bcd !== snap || done || busy) hold_err++;
         end
         total++;
         if (hold_err != 0) begin bad++; $display("FAIL rand_hold_%0d: got %0d bad cycles want 0", v, hold_err); end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_9999();
      test_overflow();
      test_blank();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
